// File: rtl/pc_unit_if.sv
// Fetch-side bus between branch/exception control and the program-counter unit.
interface pc_unit_if #(
  parameter int XLEN = 64
);
  logic            fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            trap_return;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic            fetch_valid;
  logic [XLEN-1:0] epc_out;
  logic            halted;

  modport master (
    output fetch_ready, redirect_valid, redirect_target, trap_valid, trap_pc,
           trap_return, halt_req, resume,
    input  pc_out, fetch_valid, epc_out, halted
  );

  modport slave (
    input  fetch_ready, redirect_valid, redirect_target, trap_valid, trap_pc,
           trap_return, halt_req, resume,
    output pc_out, fetch_valid, epc_out, halted
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: step on accepted fetch, redirect, trap entry/return, halt.
// All outputs come straight from registers; every update lands one cycle after its edge.
module pc_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.trap_valid) begin
          w_pc_nxt  = TRAP_VECTOR;
          w_epc_nxt = bus.trap_pc & ALIGN_MASK;
        end else if (bus.trap_return) begin
          w_pc_nxt = r_epc & ALIGN_MASK;
        end else if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_target & ALIGN_MASK;
        end else if (bus.fetch_ready) begin
          w_pc_nxt = r_pc + XLEN'(STEP);
        end
        // A halt never cancels the load chosen above in the same cycle.
        if (bus.halt_req) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.trap_valid) begin
          w_pc_nxt    = TRAP_VECTOR;
          w_epc_nxt   = bus.trap_pc & ALIGN_MASK;
          w_state_nxt = ST_RUN;
        end else if (bus.resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.epc_out     = r_epc;
  assign bus.fetch_valid = (r_state == ST_RUN);
  assign bus.halted      = (r_state == ST_HALT);
endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: each step queues its expected outputs, then checks them after the edge.
module tb_pc_unit;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] epc;
    logic            fv;
    logic            halted;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  // ctl bits: {fetch_ready, redirect_valid, trap_valid, trap_return, halt_req, resume}
  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [63:0] rt;
    logic [63:0] tp;
    logic [63:0] pc;
    logic [63:0] epc;
    logic [1:0]  flags;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  pc_unit_if #(.XLEN(XLEN)) bus ();

  pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100), .STEP(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(string n, logic [5:0] ctl, logic [63:0] rt, logic [63:0] tp,
                               logic [63:0] pc, logic [63:0] epc, logic [1:0] flags);
    stim_t s;
    s.name = n; s.ctl = ctl; s.rt = rt; s.tp = tp; s.pc = pc; s.epc = epc; s.flags = flags;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = bus.pc_out; o.epc = bus.epc_out; o.fv = bus.fetch_valid; o.halted = bus.halted;
    return o;
  endfunction

  task automatic push_exp(string n, logic [63:0] pc, logic [63:0] epc, logic [1:0] flags);
    exp_t e;
    e.name = n; e.v.pc = pc; e.v.epc = epc; e.v.fv = flags[1]; e.v.halted = flags[0];
    sb.push_back(e);
  endtask

  task automatic apply(stim_t s);
    {bus.fetch_ready, bus.redirect_valid, bus.trap_valid,
     bus.trap_return, bus.halt_req, bus.resume} = s.ctl;
    bus.redirect_target = s.rt;
    bus.trap_pc         = s.tp;
    push_exp(s.name, s.pc, s.epc, s.flags);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; obs_t o;
    apply(mk("reset_held", 6'b100000, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
               e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
    end
    reset = 1'b0;
    push_exp("boot_state", 64'h0, 64'h0, 2'b00);
    #1;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
               e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
    end
  endtask

  task automatic test_sequential();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("boot_ignores_events", 6'b111000, 64'h400, 64'h88, 64'h0, 64'h0, 2'b10));
    t.push_back(mk("seq_4", 6'b100000, 64'h0, 64'h0, 64'h4, 64'h0, 2'b10));
    t.push_back(mk("seq_8", 6'b100000, 64'h0, 64'h0, 64'h8, 64'h0, 2'b10));
    t.push_back(mk("seq_c", 6'b100000, 64'h0, 64'h0, 64'hc, 64'h0, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
  endtask

  task automatic test_stall();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("step_to_10", 6'b100000, 64'h0, 64'h0, 64'h10, 64'h0, 2'b10));
    for (int k = 0; k < 3; k++)
      t.push_back(mk($sformatf("stall_%0d", k), 6'b000000, 64'h0, 64'h0, 64'h10, 64'h0, 2'b10));
    t.push_back(mk("stall_release", 6'b100000, 64'h0, 64'h0, 64'h14, 64'h0, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("redirect_aligned", 6'b010000, 64'h203, 64'h0, 64'h200, 64'h0, 2'b10));
    t.push_back(mk("trap_beats_redirect", 6'b011000, 64'h300, 64'h47, 64'h100, 64'h44, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
  endtask

  task automatic test_trap_return();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("trap_entry", 6'b101000, 64'h0, 64'h40, 64'h100, 64'h40, 2'b10));
    t.push_back(mk("trap_fetch_104", 6'b100000, 64'h0, 64'h0, 64'h104, 64'h40, 2'b10));
    t.push_back(mk("trap_fetch_108", 6'b100000, 64'h0, 64'h0, 64'h108, 64'h40, 2'b10));
    t.push_back(mk("trap_return", 6'b100100, 64'h0, 64'h0, 64'h40, 64'h40, 2'b10));
    t.push_back(mk("trap_beats_return", 6'b001100, 64'h0, 64'h80, 64'h100, 64'h80, 2'b10));
    t.push_back(mk("return_beats_redirect", 6'b010100, 64'h500, 64'h0, 64'h80, 64'h80, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
  endtask

  task automatic test_halt();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("goto_20", 6'b010000, 64'h20, 64'h0, 64'h20, 64'h80, 2'b10));
    t.push_back(mk("halt_with_step", 6'b100010, 64'h0, 64'h0, 64'h24, 64'h80, 2'b01));
    t.push_back(mk("halt_ignores_redirect", 6'b110000, 64'h500, 64'h0, 64'h24, 64'h80, 2'b01));
    t.push_back(mk("halt_ignores_return", 6'b100100, 64'h0, 64'h0, 64'h24, 64'h80, 2'b01));
    t.push_back(mk("resume", 6'b000001, 64'h0, 64'h0, 64'h24, 64'h80, 2'b10));
    t.push_back(mk("halt_with_redirect", 6'b010010, 64'h63, 64'h0, 64'h60, 64'h80, 2'b01));
    t.push_back(mk("trap_exits_halt", 6'b001000, 64'h0, 64'h90, 64'h100, 64'h90, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    stim_t t[$]; exp_t e; obs_t o;
    t.push_back(mk("load_top", 6'b110000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                   64'hFFFF_FFFF_FFFF_FFFC, 64'h90, 2'b10));
    t.push_back(mk("wrap_to_0", 6'b100000, 64'h0, 64'h0, 64'h0, 64'h90, 2'b10));
    t.push_back(mk("after_wrap", 6'b100000, 64'h0, 64'h0, 64'h4, 64'h90, 2'b10));
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
                 e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
      end
    end
    // Reset lands between edges, so the outputs must clear with no clock involved.
    #2;
    reset = 1'b1;
    push_exp("async_reset_mid_cycle", 64'h0, 64'h0, 2'b00);
    #1;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
               e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
    end
    tick();
    reset = 1'b0;
    apply(mk("reboot_first_run", 6'b100000, 64'h0, 64'h0, 64'h0, 64'h0, 2'b10));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got pc=%h epc=%h fv=%b halted=%b, expected pc=%h epc=%h fv=%b halted=%b",
               e.name, o.pc, o.epc, o.fv, o.halted, e.v.pc, e.v.epc, e.v.fv, e.v.halted);
    end
  endtask

  initial begin
    {bus.fetch_ready, bus.redirect_valid, bus.trap_valid,
     bus.trap_return, bus.halt_req, bus.resume} = 6'b000000;
    bus.redirect_target = '0;
    bus.trap_pc         = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap_return();
    test_halt();
    test_wrap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
